// File: rtl/core_block_ctrl_pkg.sv
// Shared types and helpers for the core-side block controller.
// Optional watchdog is enabled by defining CORE_BLOCK_CTRL_TIMEOUT_EN.
package core_block_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } block_ctrl_state_t;

    // Default per-warp watchdog limit in clock cycles.
    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

    // Number of warps needed to cover tc threads (ceil division).
    function automatic int warp_count(input int tc, input int warp_size);
        return (tc + warp_size - 1) / warp_size;
    endfunction

endpackage

// File: rtl/core_block_ctrl_lane_mask_gen.sv
// Combinational active-lane mask: lane i is live when its thread index
// (wid * WARP_SIZE + i) falls below the block thread count.
module lane_mask_gen #(
    parameter int WARP_SIZE = 2,
    parameter int WID_W     = 1,
    parameter int TC_W      = 3
) (
    input  logic [WID_W-1:0]     wid_i,
    input  logic [TC_W-1:0]      tc_i,
    output logic [WARP_SIZE-1:0] mask_o
);

    // One comparator per lane.
    always_comb begin
        mask_o = '0;
        for (int i = 0; i < WARP_SIZE; i++) begin
            mask_o[i] = ((int'(wid_i) * WARP_SIZE + i) < int'(tc_i));
        end
    end

endmodule

// File: rtl/core_block_ctrl.sv
// Core-side block controller: accepts a block from dispatch, launches its
// warps one at a time to the scheduler and reports completion.
// Define CORE_BLOCK_CTRL_TIMEOUT_EN to enable the per-warp watchdog.
//
// Handshake: dispatch holds start until done; warp_start is a one-cycle
// launch pulse with warp_id/warp_mask/warp_base_tid valid alongside it and
// held until the next launch; warp_done is a one-cycle retire pulse that is
// only honoured while waiting on a launched warp. block_reset aborts any block.
module core_block_ctrl
    import core_block_ctrl_pkg::*;
#(
    parameter  int THREADS_PER_BLOCK = 4,
    parameter  int WARP_SIZE         = 2,
    parameter  int TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEFAULT,
    localparam int NUM_WARPS         = THREADS_PER_BLOCK / WARP_SIZE,
    localparam int WID_W             = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int TC_W              = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 block_reset,
    input  logic                 start,
    input  logic [7:0]           block_id,
    input  logic [TC_W-1:0]      thread_count,
    output logic                 warp_start,
    output logic [WID_W-1:0]     warp_id,
    output logic [WARP_SIZE-1:0] warp_mask,
    output logic [7:0]           warp_base_tid,
    input  logic                 warp_done,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           dbg_state_o
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_LAUNCH = LAUNCH;
    localparam logic [1:0] S_WAIT   = WAIT;
    localparam logic [1:0] S_DONE   = DONE;

    logic [1:0]           state_q, state_d;
    logic [7:0]           blk_q, blk_d;
    logic [TC_W-1:0]      tc_q, tc_d, tc_in;
    logic [WID_W-1:0]     warp_id_q, warp_id_d;
    logic [WARP_SIZE-1:0] mask_q, mask_d;
    logic [7:0]           base_q, base_d;
    logic                 start_q, start_d;
    logic                 done_q, done_d;
    logic                 more_warps;

    // Operands for the warp about to be launched.
    logic [WID_W-1:0]     sel_wid;
    logic [TC_W-1:0]      sel_tc;
    logic [7:0]           sel_blk;
    logic [7:0]           sel_base;
    logic [WARP_SIZE-1:0] sel_mask;

`ifdef CORE_BLOCK_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            error_q, error_d;
    assign error = error_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign error = 1'b0;
`endif

    assign tc_in = (int'(thread_count) > THREADS_PER_BLOCK) ? TC_W'(THREADS_PER_BLOCK)
                                                             : thread_count;
    assign more_warps = (int'(warp_id_q) + 1) < warp_count(int'(tc_q), WARP_SIZE);

    // From IDLE the first warp uses the incoming block; from WAIT the next warp uses latched data.
    always_comb begin
        sel_wid = '0;
        sel_tc  = tc_in;
        sel_blk = block_id;
        if (state_q == S_WAIT) begin
            sel_wid = warp_id_q + 1'b1;
            sel_tc  = tc_q;
            sel_blk = blk_q;
        end
    end

    assign sel_base = 8'((int'(sel_blk) * THREADS_PER_BLOCK) + (int'(sel_wid) * WARP_SIZE));

    lane_mask_gen #(
        .WARP_SIZE (WARP_SIZE),
        .WID_W     (WID_W),
        .TC_W      (TC_W)
    ) u_lane_mask_gen (
        .wid_i  (sel_wid),
        .tc_i   (sel_tc),
        .mask_o (sel_mask)
    );

    // Next-state and registered-output logic; block_reset overrides everything.
    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        tc_d      = tc_q;
        warp_id_d = warp_id_q;
        mask_d    = mask_q;
        base_d    = base_q;
        start_d   = 1'b0;
        done_d    = done_q;
`ifdef CORE_BLOCK_CTRL_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        error_d   = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    blk_d     = block_id;
                    tc_d      = tc_in;
                    warp_id_d = '0;
                    if (tc_in == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LAUNCH;
                        start_d = 1'b1;
                        mask_d  = sel_mask;
                        base_d  = sel_base;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
`ifdef CORE_BLOCK_CTRL_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (warp_done) begin
                    if (more_warps) begin
                        state_d   = S_LAUNCH;
                        warp_id_d = sel_wid;
                        start_d   = 1'b1;
                        mask_d    = sel_mask;
                        base_d    = sel_base;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
`ifdef CORE_BLOCK_CTRL_TIMEOUT_EN
                    if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = S_DONE;
            end
        endcase

        if (block_reset) begin
            state_d   = S_IDLE;
            blk_d     = '0;
            tc_d      = '0;
            warp_id_d = '0;
            mask_d    = '0;
            base_d    = '0;
            start_d   = 1'b0;
            done_d    = 1'b0;
`ifdef CORE_BLOCK_CTRL_TIMEOUT_EN
            to_cnt_d  = '0;
            error_d   = 1'b0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            blk_q     <= '0;
            tc_q      <= '0;
            warp_id_q <= '0;
            mask_q    <= '0;
            base_q    <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            tc_q      <= tc_d;
            warp_id_q <= warp_id_d;
            mask_q    <= mask_d;
            base_q    <= base_d;
            start_q   <= start_d;
            done_q    <= done_d;
        end
    end

`ifdef CORE_BLOCK_CTRL_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            error_q  <= error_d;
        end
    end
`endif

    assign warp_start    = start_q;
    assign warp_id       = warp_id_q;
    assign warp_mask     = mask_q;
    assign warp_base_tid = base_q;
    assign done          = done_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/core_block_ctrl.md
# core_block_ctrl

Core-side block controller. It receives a block from the top-level dispatch unit (`start`, block id and thread count) and splits it into warps of `WARP_SIZE` lanes. It launches those warps one at a time on the core's execution pipeline, then reports completion to dispatch through `done`. There is one instance per compute core, placed between the dispatch handshake and the core scheduler.

## Interface
- `THREADS_PER_BLOCK`, 4: maximum threads per block; must equal the dispatch value.
- `WARP_SIZE`, 2: lanes per warp; must divide `THREADS_PER_BLOCK`.
- `TIMEOUT_CYCLES`, 1024: watchdog limit per warp; used only with `CORE_BLOCK_CTRL_TIMEOUT_EN`.
- Derived `NUM_WARPS` = `THREADS_PER_BLOCK/WARP_SIZE`.
- Derived `WID_W` = max(1, $clog2(`NUM_WARPS`)).

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high; one clock, no other reset domain.
- `block_reset`  in  1  synchronous per-block reset, driven by dispatch `core_reset`.
- `start`  in  1  block valid, driven by dispatch `core_start`.
- `block_id`  in  8  block index.
- `thread_count`  in  $clog2(`THREADS_PER_BLOCK`)+1  threads in this block.
- `warp_start`  out  1  one-cycle launch pulse to the scheduler.
- `warp_id`  out  `WID_W`  index of the launched warp.
- `warp_mask`  out  `WARP_SIZE`  active-lane mask.
- `warp_base_tid`  out  8  global thread id of lane 0.
- `warp_done`  in  1  scheduler reports that the current warp has retired.
- `done`  out  1  block complete, returned to dispatch `core_done`.
- `error`  out  1  watchdog abort flag.

## Operation
- FSM states are `IDLE`, `LAUNCH`, `WAIT` and `DONE`.
- All outputs are registered.
- On `reset`, all outputs go to 0 and the FSM goes to `IDLE`.
- `block_reset` has priority over all other inputs in every state. The next state is `IDLE`, all outputs are cleared, and the latched metadata is discarded.
- `IDLE`, on `start`=1 (and `block_reset`=0):
  - Latch `block_id`.
  - Latch tc = min(`thread_count`, `THREADS_PER_BLOCK`).
  - Set `warp_id`=0.
  - If tc=0, go to `DONE`; otherwise go to `LAUNCH`.
- `LAUNCH`:
  - `warp_start`=1 for exactly one cycle.
  - Lane i of `warp_mask` = (`warp_id`·`WARP_SIZE`+i < tc).
  - `warp_base_tid` = (`block_id`·`THREADS_PER_BLOCK` + `warp_id`·`WARP_SIZE`) mod 256; it is truncated to 8 bits with no flag.
  - Next state is always `WAIT`.
- `WAIT`, on `warp_done`=1:
  - If (`warp_id`+1)·`WARP_SIZE` < tc, increment `warp_id` and go to `LAUNCH`.
  - Otherwise go to `DONE`.
- `warp_done` is sampled only in `WAIT`. It is ignored in `LAUNCH`, `IDLE` and `DONE`.
- `DONE`: `done`=1, held until `block_reset`.
  - `start` still high here does not relaunch the block.
- `warp_id`, `warp_mask` and `warp_base_tid` remain stable from `LAUNCH` until the next `LAUNCH` or `block_reset`.
- `start` falling while in `LAUNCH` or `WAIT` is ignored; only `block_reset` aborts a block.

## Timing
- `start` sampled at edge N: `warp_start` is high in cycle N+1.
- `warp_done` sampled at edge K:
  - the next `warp_start` is high in cycle K+1, or
  - `done` is high in cycle K+1 if that was the last warp.
- tc=0: `done` is high one cycle after `start` is sampled, with no `warp_start`.
- `block_reset` sampled at edge R: `done`, `error` and `warp_mask` are 0 in cycle R+1.
- A new block's `start` is accepted from cycle R+1 onward.
- `warp_start` is never high in two consecutive cycles.

## Configuration
- Macro: `CORE_BLOCK_CTRL_TIMEOUT_EN`.
- Defined:
  - A counter of $clog2(`TIMEOUT_CYCLES`)+1 bits is cleared on entry to `WAIT` and increments each `WAIT` cycle without `warp_done`.
  - After `TIMEOUT_CYCLES` such cycles, the next state is `DONE` with `error`=1.
  - `error` and `done` are held together until `block_reset`.
  - `warp_done` arriving in the same cycle as the limit wins, and no error is raised.
- Undefined: `error` is tied to 0, there is no counter, and `WAIT` waits indefinitely.

## Structure
- Package `core_block_ctrl_pkg` holds:
  - the state enum `block_ctrl_state_t`;
  - the `TIMEOUT_CYCLES` default;
  - a `warp_count(tc)` function.
- Sub-module `lane_mask_gen` is combinational. It maps (`warp_id`, tc) to `warp_mask` and is instantiated once.

## Test plan
Use `THREADS_PER_BLOCK`=4 and `WARP_SIZE`=2.
- `block_id`=3, `thread_count`=4 → two pulses:
  - first: `warp_base_tid`=12, mask 2'b11;
  - second: `warp_base_tid`=14, mask 2'b11;
  - `done`=1 one cycle after the second `warp_done`.
- `thread_count`=3 → second warp `warp_base_tid`=14, mask 2'b01; `done` after 2 warps.
- `thread_count`=2 → single `warp_start`; `done` one cycle after `warp_done`.
- `thread_count`=0 → no `warp_start`; `done`=1 one cycle after `start`.
- `block_reset` while in `WAIT` → `IDLE` next cycle, a later `warp_done` is ignored, and `done` stays 0. A new `start` with `block_id`=5 gives `warp_base_tid`=20.
- Timeout with the macro defined and `TIMEOUT_CYCLES`=8, no `warp_done` → `error`=`done`=1 after 8 `WAIT` cycles. With the macro undefined, `done` is still 0 after 100 cycles.
